data_ram_dp: RTL and testbench

Parametrised true-dual-port synchronous data memory with per-byte write enables, a hardware zero-fill engine, write-collision arbitration and an optional output register stage. Port A serves the CPU MEM stage. Port B serves the debug module. It replaces the fixed 32-bit, fixed-depth data RAM in the pipeline CPU and stays synthesisable as BRAM.

---
 rtl/data_ram_pkg.sv | 25 ++
 rtl/data_ram_out_pipe.sv | 49 ++++
 rtl/data_ram_dp.sv | 169 ++++++++++++++++
 tb/tb_data_ram_dp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the dual-port data RAM: FSM states, lane math,
// and default parameter values.
package data_ram_pkg;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_DEPTH          = 1024;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_OUT_REG        = 0;
  localparam int DEF_CLEAR_ON_RESET = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Byte-offset bits dropped from a byte address to form the word index.
  function automatic int off_w_of(input int data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/data_ram_out_pipe.sv
// Optional output register for one RAM port's {dout, addr_err, collision};
// collapses to wires when OUT_REG is 0.
module data_ram_out_pipe
  import data_ram_pkg::*;
#(
  parameter int W       = DEF_DATA_W,
  parameter int OUT_REG = DEF_OUT_REG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] dout_i,
  input  logic         err_i,
  input  logic         coll_i,
  output logic [W-1:0] dout_o,
  output logic         err_o,
  output logic         coll_o
);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [W-1:0] dout_q;
      logic         err_q;
      logic         coll_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          err_q  <= 1'b0;
          coll_q <= 1'b0;
        end else begin
          dout_q <= dout_i;
          err_q  <= err_i;
          coll_q <= coll_i;
        end
      end

      assign dout_o = dout_q;
      assign err_o  = err_q;
      assign coll_o = coll_q;
    end else begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout_o = dout_i;
      assign err_o  = err_i;
      assign coll_o = coll_i;
    end
  endgenerate

endmodule

// File: rtl/data_ram_dp.sv
// True dual-port byte-writable data RAM with zero-fill engine and collision
// arbitration (port A wins). Port A: CPU MEM stage, port B: debug module.
module data_ram_dp
  import data_ram_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int OUT_REG        = DEF_OUT_REG,
  parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic [lanes_of(DATA_W)-1:0] wea,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [DATA_W-1:0]          dina,
  output logic [DATA_W-1:0]          douta,
  output logic                       addr_err_a,
  input  logic [lanes_of(DATA_W)-1:0] web,
  input  logic [ADDR_W-1:0]          addrb,
  input  logic [DATA_W-1:0]          dinb,
  output logic [DATA_W-1:0]          doutb,
  output logic                       addr_err_b,
  output logic                       collision
);

  localparam int NB  = lanes_of(DATA_W);
  localparam int OFF = off_w_of(DATA_W);
  localparam int IW  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;

  logic [IW-1:0]   idx_a, idx_b, pa_idx;
  logic            va, vb, idle, acc_a, acc_b, same_idx, coll_now;
  logic [NB-1:0]   pa_we, pb_we;
  logic [DATA_W-1:0] pa_din;
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic            ok_a_q, ok_b_q, err_a_q, err_b_q, coll_q;
  logic [DATA_W-1:0] dout_a_s, dout_b_s;
  logic            coll_pa, coll_pb;

  assign idx_a = addra[OFF+IW-1:OFF];
  assign idx_b = addrb[OFF+IW-1:OFF];

  generate
    if (ADDR_W > OFF + IW) begin : g_hi
      assign va = ~|addra[ADDR_W-1:OFF+IW];
      assign vb = ~|addrb[ADDR_W-1:OFF+IW];
    end else begin : g_nohi
      assign va = 1'b1;
      assign vb = 1'b1;
    end
    if (OFF > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^{addra[OFF-1:0], addrb[OFF-1:0]};
    end
  endgenerate

  assign idle     = (state_q == ST_IDLE);
  assign acc_a    = idle & va;
  assign acc_b    = idle & vb;
  assign same_idx = (idx_a == idx_b);
  assign coll_now = acc_a & acc_b & same_idx & (|(wea & web));

  // The fill engine borrows port A so the array keeps exactly two ports.
  assign pa_idx = idle ? idx_a : cnt_q;
  assign pa_we  = idle ? (acc_a ? wea : '0) : '1;
  assign pa_din = idle ? dina : '0;
  assign pb_we  = acc_b ? (web & ~((acc_a && same_idx) ? wea : '0)) : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (pb_we[i]) mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
      if (pa_we[i]) mem[pa_idx][8*i +: 8] <= pa_din[8*i +: 8];
    end
    rd_a_q <= mem[pa_idx];
    rd_b_q <= mem[idx_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_a_q  <= 1'b0;
      ok_b_q  <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      ok_a_q  <= acc_a;
      ok_b_q  <= acc_b;
      err_a_q <= idle & ~va;
      err_b_q <= idle & ~vb;
      coll_q  <= coll_now;
    end
  end

  // Masking keeps the RAM read register reset-free while outputs still clear.
  assign dout_a_s = ok_a_q ? rd_a_q : '0;
  assign dout_b_s = ok_b_q ? rd_b_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req || pend_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  data_ram_out_pipe #(.W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .dout_i (dout_a_s),
    .err_i  (err_a_q),
    .coll_i (coll_q),
    .dout_o (douta),
    .err_o  (addr_err_a),
    .coll_o (coll_pa)
  );

  // Port B never raises collision; its slot is tied low.
  data_ram_out_pipe #(.W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .dout_i (dout_b_s),
    .err_i  (err_b_q),
    .coll_i (1'b0),
    .dout_o (doutb),
    .err_o  (addr_err_b),
    .coll_o (coll_pb)
  );

  assign collision = coll_pa | coll_pb;

endmodule

// File: tb/tb_data_ram_dp.sv
// Scoreboard bench: two instances (OUT_REG=0/auto-clear, OUT_REG=1/no auto-clear)
// share stimulus; a behavioural model queues expected outputs for a monitor.
module tb_data_ram_dp;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int NB    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [31:0] addra = '0, addrb = '0, dina = '0, dinb = '0;

  logic [31:0] douta0, doutb0, douta1, doutb1;
  logic        ea0, eb0, co0, bz0, ea1, eb1, co1, bz1;

  always #5 clk = ~clk;

  data_ram_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(bz0),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .addr_err_a(ea0),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .addr_err_b(eb0),
    .collision(co0)
  );

  data_ram_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .OUT_REG(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(bz1),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .addr_err_a(ea1),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .addr_err_b(eb1),
    .collision(co1)
  );

  typedef struct {
    int          due;
    logic [31:0] da;
    logic [31:0] db;
    logic        ea;
    logic        eb;
    logic        co;
  } exp_t;

  typedef struct {
    int   due;
    logic bz;
  } bexp_t;

  exp_t  q_d0[$], q_d1[$];
  bexp_t q_b0[$], q_b1[$];

  // Reference model state, one slot per instance.
  logic [31:0] m_mem [2][DEPTH];
  bit          m_busy [2];
  int          m_cnt [2];
  bit          m_pend [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string t, input exp_t e, input logic [31:0] da, input logic [31:0] db,
                     input logic ea, input logic eb, input logic co);
    chk({t, ".douta"}, da, e.da);
    chk({t, ".doutb"}, db, e.db);
    chk({t, ".addr_err_a"}, {31'd0, ea}, {31'd0, e.ea});
    chk({t, ".addr_err_b"}, {31'd0, eb}, {31'd0, e.eb});
    chk({t, ".collision"}, {31'd0, co}, {31'd0, e.co});
  endtask

  // One rising edge of the specified behaviour for instance k.
  task automatic model_step(input int k, output exp_t e, output bexp_t b);
    bit va, vb;
    int ia, ib;
    e.due = cyc + 1 + k;
    e.da = '0; e.db = '0; e.ea = 1'b0; e.eb = 1'b0; e.co = 1'b0;
    if (m_busy[k]) begin
      m_mem[k][m_cnt[k]] = '0;
      if (m_cnt[k] == DEPTH - 1) m_busy[k] = 1'b0;
      else m_cnt[k]++;
    end else begin
      va = (addra[31:6] == 26'd0);
      vb = (addrb[31:6] == 26'd0);
      ia = int'(addra[5:2]);
      ib = int'(addrb[5:2]);
      e.da = va ? m_mem[k][ia] : 32'd0;
      e.db = vb ? m_mem[k][ib] : 32'd0;
      e.ea = !va;
      e.eb = !vb;
      e.co = va && vb && (ia == ib) && ((wea & web) != 4'd0);
      for (int i = 0; i < NB; i++)
        if (vb && web[i]) m_mem[k][ib][8*i +: 8] = dinb[8*i +: 8];
      for (int i = 0; i < NB; i++)
        if (va && wea[i]) m_mem[k][ia][8*i +: 8] = dina[8*i +: 8];
      if (clear_req || m_pend[k]) begin
        m_busy[k] = 1'b1;
        m_cnt[k]  = 0;
        m_pend[k] = 1'b0;
      end
    end
    b.due = cyc + 1;
    b.bz  = m_busy[k];
  endtask

  task automatic cycle(input bit cr, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db);
    exp_t  e;
    bexp_t b;
    @(negedge clk);
    clear_req = cr; wea = wa; addra = aa; dina = da; web = wb; addrb = ab; dinb = db;
    model_step(0, e, b); q_d0.push_back(e); q_b0.push_back(b);
    model_step(1, e, b); q_d1.push_back(e); q_b1.push_back(b);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 4'h0, 32'(i * 4), 32'h0, 4'h0, 32'(i * 4 + 1), 32'h0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q_d0.delete(); q_d1.delete(); q_b0.delete(); q_b1.delete();
    #1;
    chk("rst.douta0", douta0, 32'd0);
    chk("rst.doutb0", doutb0, 32'd0);
    chk("rst.flags0", {28'd0, ea0, eb0, co0, bz0}, 32'd0);
    chk("rst.douta1", douta1, 32'd0);
    chk("rst.doutb1", doutb1, 32'd0);
    chk("rst.flags1", {28'd0, ea1, eb1, co1, bz1}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_cnt[k]  = 0;
      m_pend[k] = (k == 0);
    end
    repeat (hold) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares whatever expectation falls due on this edge.
  initial begin
    exp_t  e;
    bexp_t b;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        while (q_d0.size() != 0 && q_d0[0].due <= cyc) begin
          e = q_d0.pop_front();
          cmp("dut0", e, douta0, doutb0, ea0, eb0, co0);
        end
        while (q_d1.size() != 0 && q_d1[0].due <= cyc) begin
          e = q_d1.pop_front();
          cmp("dut1", e, douta1, doutb1, ea1, eb1, co1);
        end
        while (q_b0.size() != 0 && q_b0[0].due <= cyc) begin
          b = q_b0.pop_front();
          chk("dut0.busy", {31'd0, bz0}, {31'd0, b.bz});
        end
        while (q_b1.size() != 0 && q_b1[0].due <= cyc) begin
          b = q_b1.pop_front();
          chk("dut1.busy", {31'd0, bz1}, {31'd0, b.bz});
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;

    do_reset(2);

    // Both instances fill together; out-of-range reads avoid touching unfilled words.
    cycle(1'b1, 4'h0, 32'h8000_0000, 32'h0, 4'h0, 32'h8000_0000, 32'h0);
    idle_cycles(17);
    read_all();

    cycle(1'b0, 4'hF, 32'h8, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'h2, 32'h8, 32'h00005A00, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h8, 32'h0);

    cycle(1'b0, 4'h3, 32'h4, 32'h11111111, 4'h6, 32'h4, 32'h22222222);
    cycle(1'b0, 4'h0, 32'h4, 32'h0, 4'h0, 32'h5, 32'h0);

    cycle(1'b0, 4'hF, 32'h10, 32'h5, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'hF, 32'h10, 32'h7, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'h0, 32'h10, 32'h0, 4'h0, 32'h10, 32'h0);

    cycle(1'b0, 4'hF, 32'h0004_0000, 32'hFFFFFFFF, 4'hF, 32'h8000_0008, 32'h1);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h8, 32'h0);

    // Reset while both ports present non-zero data.
    cycle(1'b0, 4'h0, 32'h8, 32'h0, 4'h0, 32'h10, 32'h0);
    do_reset(1);
    idle_cycles(17);

    // Distinct contents, then a fill cut short by reset.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 4'hF, 32'(i * 4), $urandom | 32'h1, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle_cycles(6);
    do_reset(2);
    idle_cycles(18);
    read_all();

    cycle(1'b1, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    idle_cycles(17);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] aa, ab;
      logic [3:0]  wa, wb;
      aa = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) aa[6 + $urandom_range(0, 25)] = 1'b1;
      if ($urandom_range(0, 2) == 0) ab = {aa[31:2], 2'($urandom_range(0, 3))};
      else ab = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) ab[6 + $urandom_range(0, 25)] = 1'b1;
      wa = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      wb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      cycle($urandom_range(0, 99) == 0, wa, aa, $urandom, wb, ab, $urandom);
    end

    idle_cycles(2);
    repeat (3) @(posedge clk);
    #2;
    chk("drain.pending", 32'(q_d0.size() + q_d1.size() + q_b0.size() + q_b1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
